// File: rtl/sd_cmd_arbiter.sv
// Round-robin arbiter sharing one SPI-mode SD command engine; owns CS, builds cmd and CRC bytes.
// Latency: request seen in IDLE -> eng_start 2 cycles later; eng_done -> rsp_valid next cycle.
// Backpressure: requesters hold req with stable idx/arg until their rsp_valid; GAP ignores requests.
// Optional feature macro: SD_ARB_TIMEOUT_EN (BUSY watchdog, aborts with rsp_timeout=1).
module sd_cmd_arbiter #(
   parameter int NREQ        = 3,
   parameter int GAP_CYCLES  = 8,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*6-1:0]    req_idx,
   input  logic [NREQ*32-1:0]   req_arg,
   output logic [NREQ-1:0]      gnt,
   output logic                 rsp_valid,
   output logic [7:0]           rsp_flags,
   output logic [31:0]          rsp_data,
   output logic                 rsp_timeout,
   output logic                 eng_start,
   output logic [7:0]           eng_cmd,
   output logic [31:0]          eng_arg,
   output logic [7:0]           eng_crc,
   input  logic                 eng_done,
   input  logic [7:0]           eng_flags,
   input  logic [31:0]          eng_data,
   output logic                 cs_n
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_BUSY,
      S_RESP,
      S_GAP
   } state_t;

   state_t            state_q, state_d;
   logic [PW-1:0]     rr_q, rr_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [7:0]        cmd_q, cmd_d;
   logic [31:0]       arg_q, arg_d;
   logic [7:0]        crc_q, crc_d;
   logic [7:0]        flags_q, flags_d;
   logic [31:0]       data_q, data_d;
   logic [31:0]       gap_q, gap_d;

   // Fixed CRC7 bytes for the only commands sent before CRC checking is off (CMD0, CMD8).
   function automatic logic [7:0] crc_of(input logic [5:0] idx);
      case (idx)
         6'd0:    crc_of = 8'h95;
         6'd8:    crc_of = 8'h87;
         default: crc_of = 8'hFF;
      endcase
   endfunction

   // Round-robin pick: first set request scanning upward from rr_q with wrap.
   logic              win_vld;
   logic [PW-1:0]     win_idx;
   int                cand;
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      cand    = 0;
      for (int k = 0; k < NREQ; k++) begin
         cand = int'(rr_q) + k;
         if (cand >= NREQ) cand = cand - NREQ;
         if (!win_vld && req[cand]) begin
            win_vld = 1'b1;
            win_idx = PW'(cand);
         end
      end
   end

   logic [5:0]  sel_idx;
   logic [31:0] sel_arg;
   assign sel_idx = req_idx[int'(win_idx)*6 +: 6];
   assign sel_arg = req_arg[int'(win_idx)*32 +: 32];

`ifdef SD_ARB_TIMEOUT_EN
   logic [31:0] to_cnt_q, to_cnt_d;
   logic        to_q, to_d;
`else
   // Watchdog is compiled out; the parameter is kept for a uniform interface.
   logic        unused_timeout_cfg;
   assign unused_timeout_cfg = ^32'(TIMEOUT_CYC);
`endif

   // Next-state and datapath for the transaction FSM.
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      gnt_d   = gnt_q;
      cmd_d   = cmd_q;
      arg_d   = arg_q;
      crc_d   = crc_q;
      flags_d = flags_q;
      data_d  = data_q;
      gap_d   = gap_q;
`ifdef SD_ARB_TIMEOUT_EN
      to_cnt_d = to_cnt_q;
      to_d     = to_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (win_vld) begin
               gnt_d          = '0;
               gnt_d[win_idx] = 1'b1;
               cmd_d          = {2'b01, sel_idx};
               arg_d          = sel_arg;
               crc_d          = crc_of(sel_idx);
               rr_d           = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + 1'b1;
               state_d        = S_GRANT;
            end
         end
         S_GRANT: begin
            // eng_done here belongs to nobody and is deliberately ignored.
`ifdef SD_ARB_TIMEOUT_EN
            to_cnt_d = '0;
`endif
            state_d = S_BUSY;
         end
         S_BUSY: begin
            if (eng_done) begin
               flags_d = eng_flags;
               data_d  = eng_data;
`ifdef SD_ARB_TIMEOUT_EN
               to_d    = 1'b0;
`endif
               state_d = S_RESP;
`ifdef SD_ARB_TIMEOUT_EN
            end else if (to_cnt_q == 32'(TIMEOUT_CYC - 1)) begin
               flags_d = 8'hFF;
               data_d  = '0;
               to_d    = 1'b1;
               state_d = S_RESP;
            end else begin
               to_cnt_d = to_cnt_q + 32'd1;
`endif
            end
         end
         S_RESP: begin
            gnt_d   = '0;
            gap_d   = 32'(GAP_CYCLES - 1);
            state_d = S_GAP;
         end
         S_GAP: begin
            if (gap_q == 32'd0) state_d = S_IDLE;
            else                gap_d   = gap_q - 32'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         rr_q    <= '0;
         gnt_q   <= '0;
         cmd_q   <= '0;
         arg_q   <= '0;
         crc_q   <= '0;
         flags_q <= '0;
         data_q  <= '0;
         gap_q   <= '0;
`ifdef SD_ARB_TIMEOUT_EN
         to_cnt_q <= '0;
         to_q     <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         gnt_q   <= gnt_d;
         cmd_q   <= cmd_d;
         arg_q   <= arg_d;
         crc_q   <= crc_d;
         flags_q <= flags_d;
         data_q  <= data_d;
         gap_q   <= gap_d;
`ifdef SD_ARB_TIMEOUT_EN
         to_cnt_q <= to_cnt_d;
         to_q     <= to_d;
`endif
      end
   end

   assign gnt       = gnt_q;
   assign rsp_valid = (state_q == S_RESP);
   assign rsp_flags = flags_q;
   assign rsp_data  = data_q;
   assign eng_start = (state_q == S_BUSY);
   assign eng_cmd   = cmd_q;
   assign eng_arg   = arg_q;
   assign eng_crc   = crc_q;
   assign cs_n      = !((state_q == S_GRANT) || (state_q == S_BUSY) || (state_q == S_RESP));
`ifdef SD_ARB_TIMEOUT_EN
   assign rsp_timeout = to_q;
`else
   assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// Directed bench for sd_cmd_arbiter: reset, command/CRC table, round-robin, drop, mid-BUSY reset.
// With SD_ARB_TIMEOUT_EN defined it also exercises the BUSY watchdog (TIMEOUT_CYC=20).
module tb_sd_cmd_arbiter;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [2:0]    req;
   logic [17:0]   req_idx;
   logic [95:0]   req_arg;
   logic [2:0]    gnt;
   logic          rsp_valid;
   logic [7:0]    rsp_flags;
   logic [31:0]   rsp_data;
   logic          rsp_timeout;
   logic          eng_start;
   logic [7:0]    eng_cmd;
   logic [31:0]   eng_arg;
   logic [7:0]    eng_crc;
   logic          eng_done;
   logic [7:0]    eng_flags;
   logic [31:0]   eng_data;
   logic          cs_n;

   sd_cmd_arbiter #(.NREQ(3), .GAP_CYCLES(8), .TIMEOUT_CYC(20)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_idx(req_idx), .req_arg(req_arg),
      .gnt(gnt), .rsp_valid(rsp_valid), .rsp_flags(rsp_flags), .rsp_data(rsp_data),
      .rsp_timeout(rsp_timeout), .eng_start(eng_start), .eng_cmd(eng_cmd),
      .eng_arg(eng_arg), .eng_crc(eng_crc), .eng_done(eng_done), .eng_flags(eng_flags),
      .eng_data(eng_data), .cs_n(cs_n)
   );

   always #5 clk = ~clk;

   int vec_cnt  = 0;
   int fail_cnt = 0;
   int cyc      = 0;
   int last_gnt = 0;

   typedef struct {
      logic [2:0]  req;
      logic [17:0] idx;
      logic [95:0] arg;
      int          dly;
      logic [7:0]  flags;
      logic [31:0] data;
      logic [2:0]  exp_gnt;
      logic [7:0]  exp_cmd;
      logic [7:0]  exp_crc;
      logic [31:0] exp_arg;
   } vec_t;

   vec_t vt[4];

   task automatic tick;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // One full transaction as seen by the granted requester and the engine.
   task automatic run_txn(input logic [2:0] eg, input int dly, input logic [7:0] fl,
                          input logic [31:0] dt, input logic [7:0] ec, input logic [7:0] ecrc,
                          input logic [31:0] ea, input bit drop, input int exp_gap);
      int n;
      n = 0;
      while (gnt == 3'b000 && n < 100) begin
         tick;
         n++;
      end
      if (gnt == 3'b000) begin
         chk("gnt_wait_expired", 64'd0, 64'd1);
         return;
      end
      if (exp_gap > 0) chk("grant_spacing", 64'(cyc - last_gnt), 64'(exp_gap));
      last_gnt = cyc;
      chk("grant_gnt", 64'(gnt), 64'(eg));
      chk("grant_cmd", 64'(eng_cmd), 64'(ec));
      chk("grant_crc", 64'(eng_crc), 64'(ecrc));
      chk("grant_arg", 64'(eng_arg), 64'(ea));
      chk("grant_cs_n", 64'(cs_n), 64'd0);
      chk("grant_start", 64'(eng_start), 64'd0);
      if (drop) req = 3'b000;
      tick;
      chk("busy_start", 64'(eng_start), 64'd1);
      chk("busy_cs_n", 64'(cs_n), 64'd0);
      repeat (dly) tick;
      eng_done  = 1'b1;
      eng_flags = fl;
      eng_data  = dt;
      tick;
      eng_done  = 1'b0;
      eng_flags = 8'h00;
      eng_data  = 32'h0;
      chk("resp_valid", 64'(rsp_valid), 64'd1);
      chk("resp_gnt", 64'(gnt), 64'(eg));
      chk("resp_flags", 64'(rsp_flags), 64'(fl));
      chk("resp_data", 64'(rsp_data), 64'(dt));
      chk("resp_timeout", 64'(rsp_timeout), 64'd0);
      chk("resp_start", 64'(eng_start), 64'd0);
      chk("resp_cs_n", 64'(cs_n), 64'd0);
      tick;
      chk("gap_valid", 64'(rsp_valid), 64'd0);
      chk("gap_gnt", 64'(gnt), 64'd0);
      chk("gap_cs_n", 64'(cs_n), 64'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [2:0] rr_exp[9];
      int w;
      bit seen;
      int n;

      vt[0] = '{3'b010, {6'd0, 6'd17, 6'd0}, {32'd0, 32'h0000_0200, 32'd0}, 9,
                8'h00, 32'hDEAD_BEEF, 3'b010, 8'h51, 8'hFF, 32'h0000_0200};
      vt[1] = '{3'b001, {6'd5, 6'd9, 6'd0}, {32'h1, 32'h2, 32'h0}, 2,
                8'h01, 32'h0000_0000, 3'b001, 8'h40, 8'h95, 32'h0};
      vt[2] = '{3'b100, {6'd8, 6'd0, 6'd0}, {32'h0000_01AA, 32'h0, 32'h0}, 3,
                8'h01, 32'h0000_01AA, 3'b100, 8'h48, 8'h87, 32'h0000_01AA};
      vt[3] = '{3'b001, {6'd0, 6'd0, 6'd63}, {32'h0, 32'h0, 32'hFFFF_FFFF}, 0,
                8'h05, 32'h1234_5678, 3'b001, 8'h7F, 8'hFF, 32'hFFFF_FFFF};

      rst_n = 1'b0; req = 3'b111; req_idx = '0; req_arg = '0;
      eng_done = 1'b0; eng_flags = 8'h00; eng_data = 32'h0;

      // Reset held three cycles with every request raised.
      repeat (3) begin
         tick;
         chk("reset_cs_n", 64'(cs_n), 64'd1);
         chk("reset_gnt", 64'(gnt), 64'd0);
         chk("reset_start", 64'(eng_start), 64'd0);
         chk("reset_valid", 64'(rsp_valid), 64'd0);
      end
      chk("reset_flags", 64'(rsp_flags), 64'd0);
      chk("reset_data", 64'(rsp_data), 64'd0);
      chk("reset_cmd", 64'({eng_cmd, eng_crc}), 64'd0);
      chk("reset_arg", 64'(eng_arg), 64'd0);
      chk("reset_timeout", 64'(rsp_timeout), 64'd0);
      req = 3'b000;
      rst_n = 1'b1;
      tick;

      // Table of single-requester transactions, each followed by the CS-high gap.
      for (int i = 0; i < 4; i++) begin
         req_idx = vt[i].idx;
         req_arg = vt[i].arg;
         req     = vt[i].req;
         run_txn(vt[i].exp_gnt, vt[i].dly, vt[i].flags, vt[i].data, vt[i].exp_cmd,
                 vt[i].exp_crc, vt[i].exp_arg, 1'b0, 0);
         req = 3'b000;
         for (int g = 1; g < 8; g++) begin
            tick;
            chk("gap_hold_cs_n", 64'(cs_n), 64'd1);
         end
         tick;
         chk("idle_cs_n", 64'(cs_n), 64'd1);
         chk("idle_gnt", 64'(gnt), 64'd0);
      end

      // Requester drops req once granted: transaction still completes.
      req_idx = {6'd0, 6'd24, 6'd0};
      req_arg = {32'h0, 32'h0000_0400, 32'h0};
      req = 3'b010;
      run_txn(3'b010, 4, 8'h00, 32'hCAFE_F00D, 8'h58, 8'hFF, 32'h0000_0400, 1'b1, 0);
      repeat (10) tick;

      // Round-robin from a fresh pointer, 4+GAP cycle grant spacing.
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      req_idx = {6'd3, 6'd2, 6'd1};
      req_arg = {32'h0000_0102, 32'h0000_0101, 32'h0000_0100};
      rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b100, 3'b001};
      req = 3'b111;
      for (int i = 0; i < 9; i++) begin
         if (i == 6) req = 3'b101;
         w = (rr_exp[i] == 3'b001) ? 0 : (rr_exp[i] == 3'b010) ? 1 : 2;
         run_txn(rr_exp[i], 0, 8'h00, 32'hA5A5_0000 + 32'(i), 8'h41 + 8'(w), 8'hFF,
                 32'h0000_0100 + 32'(w), 1'b0, (i == 0) ? 0 : 12);
      end
      req = 3'b000;
      repeat (10) tick;

      // Reset while BUSY: start and CS drop next cycle, no response ever issued.
      req = 3'b001;
      n = 0;
      while (!eng_start && n < 20) begin
         tick;
         n++;
      end
      chk("midbusy_reached", 64'(eng_start), 64'd1);
      rst_n = 1'b0;
      tick;
      chk("midbusy_start", 64'(eng_start), 64'd0);
      chk("midbusy_cs_n", 64'(cs_n), 64'd1);
      chk("midbusy_gnt", 64'(gnt), 64'd0);
      rst_n = 1'b1;
      req = 3'b000;
      eng_done = 1'b1;
      eng_flags = 8'h3C;
      tick;
      eng_done = 1'b0;
      eng_flags = 8'h00;
      seen = 1'b0;
      repeat (30) begin
         if (rsp_valid) seen = 1'b1;
         tick;
      end
      chk("midbusy_no_rsp", 64'(seen), 64'd0);
      chk("midbusy_flags", 64'(rsp_flags), 64'd0);

`ifdef SD_ARB_TIMEOUT_EN
      // Watchdog expiry, then eng_done landing on the expiry cycle.
      req_idx = {6'd0, 6'd0, 6'd17};
      req_arg = {32'h0, 32'h0, 32'h0000_0800};
      req = 3'b001;
      run_txn(3'b001, 1, 8'h00, 32'h55AA_55AA, 8'h51, 8'hFF, 32'h0000_0800, 1'b0, 0);
      for (int r = 0; r < 2; r++) begin
         n = 0;
         while (gnt == 3'b000 && n < 100) begin
            tick;
            n++;
         end
         chk("to_gnt", 64'(gnt), 64'd1);
         tick;
         n = 0;
         for (int c = 0; c < 100; c++) begin
            if (eng_start) n++;
            if (r == 1 && n == 20) begin
               eng_done = 1'b1;
               eng_flags = 8'h02;
               eng_data = 32'h0000_0077;
            end
            tick;
            eng_done = 1'b0;
            if (rsp_valid) break;
         end
         chk("to_busy_cycles", 64'(n), 64'd20);
         chk("to_valid", 64'(rsp_valid), 64'd1);
         chk("to_timeout", 64'(rsp_timeout), (r == 0) ? 64'd1 : 64'd0);
         chk("to_flags", 64'(rsp_flags), (r == 0) ? 64'hFF : 64'h02);
         chk("to_data", 64'(rsp_data), (r == 0) ? 64'h0 : 64'h77);
         chk("to_start", 64'(eng_start), 64'd0);
         tick;
      end
      req = 3'b000;
      repeat (10) tick;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
      $finish;
   end

endmodule
